// File: rtl/serial_logic_unit.sv
// Bit-serial ALU: one 1-bit logic/full-adder cell processes the operands LSB
// first over WIDTH cycles, then reports result and flags with a done pulse.
module serial_logic_unit #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b11;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             cout_q, cout_d;
    logic             zero_q, zero_d;

    logic             bit_s;
    logic             cmaj_s;
    logic             arith_s;
    logic [WIDTH-1:0] sh_next_s;

    // The single 1-bit cell shared by all four operations
    always_comb begin
        cmaj_s  = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
        arith_s = op_q[1];
        case (op_q)
            OP_AND:  bit_s = a_q[0] & b_q[0];
            OP_OR:   bit_s = a_q[0] | b_q[0];
            default: bit_s = a_q[0] ^ b_q[0] ^ c_q;
        endcase
        sh_next_s = {bit_s, sh_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        c_d     = c_q;
        sh_d    = sh_q;
        res_d   = res_q;
        cout_d  = cout_q;
        zero_d  = zero_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    // SUB is computed as a + ~b + 1
                    a_d     = a;
                    b_d     = (op == OP_SUB) ? ~b : b;
                    op_d    = op;
                    c_d     = (op == OP_SUB);
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                sh_d  = sh_next_s;
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = arith_s ? cmaj_s : c_q;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    state_d = S_DONE;
                    res_d   = sh_next_s;
                    cout_d  = arith_s & cmaj_s;
                    zero_d  = (sh_next_s == '0);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            c_q     <= 1'b0;
            sh_q    <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            c_q     <= c_d;
            sh_q    <= sh_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            zero_q  <= zero_d;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign result    = res_q;
    assign carry_out = cout_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_serial_logic_unit.sv
// Directed-vector bench for serial_logic_unit (WIDTH=8).
module tb_serial_logic_unit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       carry_out;
    logic       zero;

    int n_tests = 0;
    int n_fail  = 0;

    serial_logic_unit #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result),
        .carry_out(carry_out), .zero(zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       cout;
        logic       zero;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one start pulse and wait for done; reports latency in edges and busy cycles
    task automatic run_op(input logic [1:0] o, input logic [7:0] aa, input logic [7:0] bb,
                          output int lat, output int busy_cnt, output bit stable);
        logic [7:0] held;
        @(negedge clk);
        held  = result;
        start = 1'b1; op = o; a = aa; b = bb;
        @(negedge clk);
        start = 1'b0;
        a = 8'h00; b = 8'h00; op = 2'b00;
        lat = 1; busy_cnt = 0; stable = 1'b1;
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            if (result !== held) stable = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int  lat, bc, dcount, first_done, gap;
        bit  stable;
        bit  busy_low_seen;

        vecs[0]  = '{2'b00, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
        vecs[1]  = '{2'b10, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
        vecs[2]  = '{2'b01, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
        vecs[3]  = '{2'b11, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
        vecs[4]  = '{2'b11, 8'h07, 8'h05, 8'h02, 1'b1, 1'b0};
        vecs[5]  = '{2'b10, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        vecs[6]  = '{2'b01, 8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b0};
        vecs[7]  = '{2'b11, 8'h33, 8'h33, 8'h00, 1'b1, 1'b1};
        vecs[8]  = '{2'b10, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0};
        vecs[9]  = '{2'b00, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b1};
        vecs[10] = '{2'b11, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0};

        rst_n = 1'b0; start = 1'b0; op = 2'b00; a = 8'h00; b = 8'h00;
        #2;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        check("reset_flags", {30'd0, carry_out, zero}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bc, stable);
            check($sformatf("v%0d_done", i), 32'(done), 32'd1);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'd9);
            check($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'd8);
            check($sformatf("v%0d_result_stable", i), 32'(stable), 32'd1);
            check($sformatf("v%0d_result", i), 32'(result), 32'(vecs[i].res));
            check($sformatf("v%0d_carry", i), 32'(carry_out), 32'(vecs[i].cout));
            check($sformatf("v%0d_zero", i), 32'(zero), 32'(vecs[i].zero));
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
            check($sformatf("v%0d_idle_busy", i), 32'(busy), 32'd0);
            check($sformatf("v%0d_result_held", i), 32'(result), 32'(vecs[i].res));
        end

        // start pulsed during RUN must not disturb the in-flight ADD
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 8'h10; b = 8'h20;
        dcount = 0; first_done = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = (k == 3);
            op = 2'b00; a = 8'h00; b = 8'h00;
            if (done) begin
                dcount++;
                if (first_done == 0) begin
                    first_done = k;
                    check("ignore_result", 32'(result), 32'h30);
                end
            end
        end
        start = 1'b0;
        check("ignore_done_count", 32'(dcount), 32'd1);
        check("ignore_latency", 32'(first_done), 32'd9);

        // back-to-back: start held through the DONE cycle
        run_op(2'b01, 8'h10, 8'h20, lat, bc, stable);
        check("b2b_first_done", 32'(done), 32'd1);
        check("b2b_first_result", 32'(result), 32'h30);
        start = 1'b1; op = 2'b10; a = 8'h01; b = 8'h01;
        @(negedge clk);
        start = 1'b0; op = 2'b00; a = 8'h00; b = 8'h00;
        gap = 1; busy_low_seen = 1'b0;
        while (!done && gap < 20) begin
            if (!busy) busy_low_seen = 1'b1;
            @(negedge clk);
            gap++;
        end
        check("b2b_gap", 32'(gap), 32'd9);
        check("b2b_busy_low", 32'(busy_low_seen), 32'd0);
        check("b2b_second_result", 32'(result), 32'h02);
        check("b2b_second_flags", {30'd0, carry_out, zero}, 32'd0);

        // asynchronous reset in RUN cycle 4
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 8'h10; b = 8'h20;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_pre_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_flags", {30'd0, carry_out, zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("midrst_no_done", 32'(dcount), 32'd0);
        run_op(2'b01, 8'h0F, 8'hA0, lat, bc, stable);
        check("post_rst_latency", 32'(lat), 32'd9);
        check("post_rst_result", 32'(result), 32'hAF);
        check("post_rst_flags", {30'd0, carry_out, zero}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_logic_unit.md
Name: serial_logic_unit

Overview:
- Bit-serial ALU: latches two WIDTH-bit operands and an opcode on a start pulse.
- Processes one bit per clock, LSB first, through a single 1-bit logic/full-adder cell, then reports the result with a one-cycle done pulse.
- Produces the same results as the parallel combinational ALU. It trades latency for area and serves as a sequential drop-in where only one 1-bit cell per function can be afforded.
- Sits between the operand/command source (start/op/a/b) and the result consumer (done/result/flags).

Parameters:
- WIDTH, 8, operand and result width in bits (legal range ≥ 2).
- CW, $clog2(WIDTH)+1, width of the internal bit counter (derived, not overridden).

Ports:
- clk  input  1  single system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on a rising clk edge in IDLE or DONE.
- op  input  2  opcode sampled with start: 00 AND, 01 OR, 10 ADD, 11 SUB (a−b).
- a  input  WIDTH  operand A, sampled with start.
- b  input  WIDTH  operand B, sampled with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result and flags are valid.
- result  output  WIDTH  operation result; held until the next accepted start.
- carry_out  output  1  ADD: carry out of the MSB. SUB: 1 = no borrow (a ≥ b unsigned). AND/OR: 0.
- zero  output  1  result == 0; held with result.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values (asserted immediately, independent of clk): state=IDLE, busy=0, done=0, result=0, carry_out=0, zero=0, counter=0, operand shift registers=0, carry flop=0.
- States:
  - IDLE: waits for start.
  - RUN: WIDTH bit-cycles.
  - DONE: one cycle.
- Start acceptance (edge E0):
  - In IDLE or DONE with start=1: latch a, op, internal carry, and the B operand, clear counter, go to RUN.
  - Internal carry = 1 for SUB, else 0.
  - B operand is ~b for SUB, else b.
- RUN, at each edge Ek (k = 1..WIDTH):
  - Compute bit k−1 from the operand LSBs:
    - AND: a0 & b0.
    - OR: a0 | b0.
    - ADD/SUB: sum = a0 ^ b0 ^ c, c ← majority(a0, b0, c).
  - Shift the result register right, inserting the new bit at the MSB.
  - Shift both operand registers right.
  - Increment the counter.
- Leaving RUN: at edge E(WIDTH), go to DONE. In the same edge load result, carry_out (final c for ADD/SUB, 0 otherwise) and zero.
- DONE timing: done=1 for exactly the cycle after E(WIDTH). Total latency is start edge to done high = WIDTH+1 edges.
- DONE exit: next edge goes to IDLE, unless start=1, in which case the request is accepted back-to-back as above.
- busy: 1 exactly in RUN; 0 in IDLE and DONE.
- start while busy=1: ignored, with no latching and no effect on the in-flight operation.
- Output stability: result, carry_out and zero change only at the edge entering DONE. They remain stable through IDLE and through the following RUN until its own completion.
- Arithmetic: modulo 2^WIDTH, operands unsigned; no overflow flag.
- Reset mid-RUN: aborts immediately to reset values. No done pulse is produced for the aborted operation.
- Invalid counter values are unreachable. The FSM default branch returns to IDLE.

Test Plan:
- WIDTH=8, op=AND, a=0xF0, b=0x3C, start 1 cycle -> busy high 8 cycles; done at edge 9; result=0x30, carry_out=0, zero=0.
- op=ADD, a=0xFF, b=0x01 -> result=0x00, carry_out=1, zero=1 on done. Then op=OR, a=0x00, b=0x00 -> result=0x00, zero=1, carry_out=0.
- op=SUB, a=0x05, b=0x07 -> result=0xFE, carry_out=0. Then SUB a=0x07, b=0x05 -> result=0x02, carry_out=1.
- Busy-ignore: start ADD 0x10+0x20, pulse start with op=AND a=0x00 b=0x00 at RUN cycle 3 -> single done, result=0x30; only one done pulse observed.
- Back-to-back: hold start high through the DONE cycle with new operands ADD 0x01+0x01 -> done pulses separated by exactly 9 cycles; second result=0x02; busy low only during the DONE cycle.
- Reset mid-operation: assert rst_n=0 asynchronously at RUN cycle 4 -> busy/done/result/flags go to 0 without a clock edge. After release, a new OR 0x0F|0xA0 gives result=0xAF at the expected latency.
